// File: rtl/output_sram_collector_pkg.sv
// Shared types and constants for the bank-to-output-SRAM collector.
// Bank packet layout matches the vertex accumulation bank side of the protocol.
package output_sram_collector_pkg;

    localparam int FV_SIZE_C     = 16;
    localparam int MAX_FV_NUM_C  = 16;
    localparam int MAX_NODE_ID_C = 64;
    localparam int NODE_W_C      = $clog2(MAX_NODE_ID_C);

    typedef struct packed {
        logic                          req;
        logic                          Grant_valid;
        logic                          sos;
        logic                          eos;
        logic [1:0][FV_SIZE_C-1:0]     data;
        logic [NODE_W_C-1:0]           Node_id;
    } Bank_Req2Req_Output_SRAM;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } coll_state_e;

endpackage

// File: rtl/output_sram_collector_if.sv
// Bank request/stream bundle plus the SRAM write port of the collector.
// master = bank/SRAM side, slave = collector.
interface output_sram_collector_if
    import output_sram_collector_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int FV_SIZE   = FV_SIZE_C,
    parameter int NODE_W    = NODE_W_C,
    parameter int ADDR_W    = NODE_W_C + $clog2(MAX_FV_NUM_C / 2)
) ();

    Bank_Req2Req_Output_SRAM [NUM_BANKS-1:0] bank_pkt;
    logic [NUM_BANKS-1:0]                    req_grant;
    logic                                    sram_wen;
    logic [ADDR_W-1:0]                       sram_addr;
    logic [2*FV_SIZE-1:0]                    sram_wdata;
    logic                                    node_done;
    logic [NODE_W-1:0]                       node_done_id;
    logic                                    busy;
    logic                                    proto_err;

    modport master (
        output bank_pkt,
        input  req_grant, sram_wen, sram_addr, sram_wdata,
        input  node_done, node_done_id, busy, proto_err
    );

    modport slave (
        input  bank_pkt,
        output req_grant, sram_wen, sram_addr, sram_wdata,
        output node_done, node_done_id, busy, proto_err
    );

endinterface

// File: rtl/output_sram_collector_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
// The pointer only moves when a grant is actually issued.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_gnt
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_cand  = r_last;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((int'(r_last) + k) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
        o_gnt = '0;
        if (i_en && w_found) o_gnt[w_pick] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)                r_last <= IDX_W'(N - 1);
        else if (i_en && w_found) r_last <= w_pick;
    end

endmodule

// File: rtl/output_sram_collector.sv
// Collects granted bank streams (sos..eos, two FVs per beat) into the output
// feature SRAM, one row per beat at Node_id*ROWS_PER_NODE + beat index.
module output_sram_collector
    import output_sram_collector_pkg::*;
#(
    parameter int NUM_BANKS     = 4,
    parameter int FV_SIZE       = FV_SIZE_C,
    parameter int MAX_FV_NUM    = MAX_FV_NUM_C,
    parameter int NODE_W        = NODE_W_C,
    parameter int ROWS_PER_NODE = MAX_FV_NUM / 2,
    parameter int ADDR_W        = NODE_W + $clog2(ROWS_PER_NODE)
) (
    input  logic                   clk,
    input  logic                   reset,
    output_sram_collector_if.slave io_bus
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int BEAT_W = $clog2(ROWS_PER_NODE + 1);

    coll_state_e             r_state, w_state_nxt;
    logic [NUM_BANKS-1:0]    r_pending, w_req, w_gv, w_gnt, w_cur_mask;
    logic [BANK_W-1:0]       r_cur_bank, w_cur_bank_nxt, w_gnt_idx;
    logic [NODE_W-1:0]       r_cur_node, w_cur_node_nxt;
    logic [BEAT_W-1:0]       r_beat_idx, w_beat_nxt;
    Bank_Req2Req_Output_SRAM w_pkt;

    logic                    r_wen, w_wen;
    logic [ADDR_W-1:0]       r_addr, w_addr;
    logic [2*FV_SIZE-1:0]    r_wdata, w_wdata;
    logic                    r_done, w_done;
    logic [NODE_W-1:0]       r_done_id, w_done_id;
    logic                    r_err, w_err;

    function automatic logic [ADDR_W-1:0] row_addr(input logic [NODE_W-1:0] node,
                                                   input logic [BEAT_W-1:0] beat);
        return ADDR_W'(node) * ADDR_W'(ROWS_PER_NODE) + ADDR_W'(beat);
    endfunction

    rr_arbiter #(.N(NUM_BANKS)) u_arb (
        .clk   (clk),
        .reset (reset),
        .i_req (r_pending),
        .i_en  ((r_state == ST_IDLE) && !reset),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            w_req[i] = io_bus.bank_pkt[i].req;
            w_gv[i]  = io_bus.bank_pkt[i].Grant_valid;
            if (w_gnt[i]) w_gnt_idx = BANK_W'(i);
        end
        w_cur_mask = NUM_BANKS'(1) << r_cur_bank;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_bank_nxt = r_cur_bank;
        w_cur_node_nxt = r_cur_node;
        w_beat_nxt     = r_beat_idx;
        w_pkt          = '0;
        w_wen          = 1'b0;
        w_addr         = r_addr;
        w_wdata        = r_wdata;
        w_done         = 1'b0;
        w_done_id      = r_done_id;
        w_err          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_gnt) begin
                    w_pkt = io_bus.bank_pkt[w_gnt_idx];
                    if (|(w_gv & ~w_gnt)) w_err = 1'b1;
                    if (w_pkt.Grant_valid && w_pkt.sos) begin
                        w_wen          = 1'b1;
                        w_addr         = row_addr(w_pkt.Node_id, '0);
                        w_wdata        = {w_pkt.data[1], w_pkt.data[0]};
                        w_cur_bank_nxt = w_gnt_idx;
                        w_cur_node_nxt = w_pkt.Node_id;
                        w_beat_nxt     = BEAT_W'(1);
                        if (w_pkt.eos) begin
                            w_done    = 1'b1;
                            w_done_id = w_pkt.Node_id;
                        end else begin
                            w_state_nxt = ST_STREAM;
                        end
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (|w_gv) begin
                    w_err = 1'b1;
                end
            end
            ST_STREAM: begin
                w_pkt = io_bus.bank_pkt[r_cur_bank];
                if (|(w_gv & ~w_cur_mask)) w_err = 1'b1;
                if (w_pkt.Grant_valid) begin
                    // Beats past the node's reserved rows are dropped, not wrapped.
                    if (r_beat_idx == BEAT_W'(ROWS_PER_NODE)) begin
                        w_err = 1'b1;
                    end else begin
                        w_wen      = 1'b1;
                        w_addr     = row_addr(r_cur_node, r_beat_idx);
                        w_wdata    = {w_pkt.data[1], w_pkt.data[0]};
                        w_beat_nxt = r_beat_idx + BEAT_W'(1);
                        w_done     = w_pkt.eos;
                        if (w_pkt.eos) w_done_id = r_cur_node;
                    end
                    if (w_pkt.eos) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_wen     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= (r_pending & ~w_gnt) | w_req;
            r_wen     <= w_wen;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_done    <= w_done;
            r_done_id <= w_done_id;
            r_err     <= r_err | w_err;
        end
    end

    always_ff @(posedge clk) begin
        r_cur_bank <= w_cur_bank_nxt;
        r_cur_node <= w_cur_node_nxt;
        r_beat_idx <= w_beat_nxt;
    end

    assign io_bus.req_grant    = w_gnt;
    assign io_bus.sram_wen     = r_wen;
    assign io_bus.sram_addr    = r_addr;
    assign io_bus.sram_wdata   = r_wdata;
    assign io_bus.node_done    = r_done;
    assign io_bus.node_done_id = r_done_id;
    assign io_bus.busy         = (|r_pending) || (r_state == ST_STREAM);
    assign io_bus.proto_err    = r_err;

endmodule

// File: tb/tb_output_sram_collector.sv
// Bench for output_sram_collector: behavioural bank models, a phase table,
// hand-written corner sequences and randomized phases against a write-list model.
module tb_output_sram_collector;
    import output_sram_collector_pkg::*;

    localparam int NB   = 4;
    localparam int FV   = 16;
    localparam int NW   = 6;
    localparam int ROWS = 8;
    localparam int AW   = 9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    output_sram_collector_if #(.NUM_BANKS(NB), .FV_SIZE(FV), .NODE_W(NW), .ADDR_W(AW)) bus ();

    output_sram_collector #(
        .NUM_BANKS(NB), .FV_SIZE(FV), .MAX_FV_NUM(16), .NODE_W(NW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic          b_req   [NB];
    int            b_len   [NB];
    int            b_pos   [NB];
    logic [NW-1:0] b_node  [NB];
    logic [15:0]   b_salt  [NB];
    logic          b_rogue [NB];
    logic          stall;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          done;
        logic [NW-1:0] id;
    } wr_t;

    typedef struct {
        logic [3:0] mask;
        int         len;
        int         node;
        int         rogue_b;
        int         rogue_t;
        int         n_ord;
        int         ord [4];
        logic       err;
    } vec_t;

    wr_t  exp_q [$];
    int   exp_ord [$];
    int   got_ord [$];
    int   m_last;
    logic exp_err;
    int   cur_t, first_gnt, n_wr, stall_wr;

    function automatic logic [31:0] beat_word(input logic [15:0] salt, input int idx);
        logic [15:0] lo;
        lo = salt + 16'(2 * idx);
        return {lo + 16'd1, lo};
    endfunction

    always_comb begin : bank_model
        Bank_Req2Req_Output_SRAM p;
        logic [31:0] w;
        for (int b = 0; b < NB; b++) begin
            p = '0;
            w = '0;
            p.req     = b_req[b];
            p.Node_id = b_node[b];
            if (b_pos[b] == 0 && b_len[b] > 0 && bus.req_grant[b]) begin
                p.Grant_valid = 1'b1;
                p.sos         = 1'b1;
                p.eos         = (b_len[b] == 1);
                w             = beat_word(b_salt[b], 0);
            end else if (b_pos[b] > 0 && !stall) begin
                p.Grant_valid = 1'b1;
                p.eos         = (b_pos[b] == b_len[b] - 1);
                w             = beat_word(b_salt[b], b_pos[b]);
            end
            if (b_rogue[b]) p.Grant_valid = 1'b1;
            p.data[0] = w[15:0];
            p.data[1] = w[31:16];
            bus.bank_pkt[b] = p;
        end
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic launch(input int b, input int node, input int len);
        b_node[b] = NW'(node);
        b_len[b]  = len;
        b_pos[b]  = 0;
        b_salt[b] = 16'($urandom);
        b_req[b]  = 1'b1;
    endtask

    // Model: round-robin order from the requesting set, then each node's rows in order.
    task automatic plan();
        exp_ord.delete();
        for (int k = 1; k <= NB; k++) begin
            int b;
            b = (m_last + k) % NB;
            if (b_req[b]) exp_ord.push_back(b);
        end
        foreach (exp_ord[i]) begin
            int b;
            b = exp_ord[i];
            m_last = b;
            if (b_len[b] == 0 || b_len[b] > ROWS) exp_err = 1'b1;
            for (int k = 0; k < b_len[b] && k < ROWS; k++) begin
                wr_t e;
                e.addr = AW'(int'(b_node[b]) * ROWS + k);
                e.data = beat_word(b_salt[b], k);
                e.done = (k == b_len[b] - 1);
                e.id   = b_node[b];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        logic fire [NB];
        @(negedge clk);
        check("grant_onehot", 64'($onehot0(bus.req_grant)), 64'd1);
        for (int b = 0; b < NB; b++) begin
            fire[b] = (b_pos[b] > 0 && !stall) ||
                      (b_pos[b] == 0 && b_len[b] > 0 && bus.req_grant[b]);
            if (bus.req_grant[b]) begin
                got_ord.push_back(b);
                if (first_gnt < 0) first_gnt = cur_t;
            end
        end
        @(posedge clk);
        #1;
        for (int b = 0; b < NB; b++) begin
            if (fire[b]) begin
                if (b_pos[b] == b_len[b] - 1) begin
                    b_pos[b] = 0;
                    b_len[b] = 0;
                end else begin
                    b_pos[b]++;
                end
            end
        end
        if (bus.sram_wen) begin
            n_wr++;
            if (stall) stall_wr++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h, expected no write", bus.sram_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(bus.sram_addr), 64'(e.addr));
                check("wr_data", 64'(bus.sram_wdata), 64'(e.data));
                check("wr_done", 64'(bus.node_done), 64'(e.done));
                if (e.done) check("wr_done_id", 64'(bus.node_done_id), 64'(e.id));
            end
        end else begin
            check("done_without_wen", 64'(bus.node_done), 64'd0);
        end
    endtask

    task automatic run_phase(input int rogue_b, input int rogue_t, input int stall_pct,
                             input int stall_b, input int stall_n);
        int   t;
        int   sn;
        logic fin;
        plan();
        got_ord.delete();
        first_gnt = -1;
        stall_wr  = 0;
        sn        = stall_n;
        for (t = 0; t < 300; t++) begin
            cur_t = t;
            stall = 1'b0;
            if (stall_pct > 0 && $urandom_range(99) < stall_pct) stall = 1'b1;
            if (sn > 0 && b_pos[stall_b] == 3) begin
                stall = 1'b1;
                sn--;
            end
            for (int b = 0; b < NB; b++) b_rogue[b] = (b == rogue_b && t == rogue_t);
            tick();
            if (t == 0) for (int b = 0; b < NB; b++) b_req[b] = 1'b0;
            fin = !bus.busy;
            for (int b = 0; b < NB; b++) if (b_len[b] != 0) fin = 1'b0;
            if (t >= 1 && fin) break;
        end
        stall = 1'b0;
        for (int b = 0; b < NB; b++) b_rogue[b] = 1'b0;
        check("phase_finished", 64'(t < 300), 64'd1);
        check("leftover_writes", 64'(exp_q.size()), 64'd0);
        check("grant_count", 64'(got_ord.size()), 64'(exp_ord.size()));
        for (int i = 0; i < got_ord.size() && i < exp_ord.size(); i++)
            check("model_grant_order", 64'(got_ord[i]), 64'(exp_ord[i]));
        check("first_grant_latency", 64'(first_gnt), 64'd1);
    endtask

    task automatic apply_row(input vec_t v);
        for (int b = 0; b < NB; b++) if (v.mask[b]) launch(b, v.node + b, v.len);
        run_phase(v.rogue_b, v.rogue_t, 0, 0, 0);
        for (int k = 0; k < v.n_ord; k++) begin
            if (k < got_ord.size()) check("tbl_grant_order", 64'(got_ord[k]), 64'(v.ord[k]));
            else check("tbl_grant_missing", 64'(got_ord.size()), 64'(v.n_ord));
        end
        check("tbl_proto_err", 64'(bus.proto_err), 64'(v.err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_grant"}, 64'(bus.req_grant), 64'd0);
        check({tag, "_sram_wen"}, 64'(bus.sram_wen), 64'd0);
        check({tag, "_sram_addr"}, 64'(bus.sram_addr), 64'd0);
        check({tag, "_sram_wdata"}, 64'(bus.sram_wdata), 64'd0);
        check({tag, "_node_done"}, 64'(bus.node_done), 64'd0);
        check({tag, "_node_done_id"}, 64'(bus.node_done_id), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_proto_err"}, 64'(bus.proto_err), 64'd0);
    endtask

    initial begin
        vec_t tbl [6];
        int   any;
        tbl[0] = '{4'b1111, 2, 10, -1, 0, 4, '{0, 1, 2, 3}, 1'b0};
        tbl[1] = '{4'b1010, 3, 20, -1, 0, 2, '{1, 3, 0, 0}, 1'b0};
        tbl[2] = '{4'b0001, 8,  5, -1, 0, 1, '{0, 0, 0, 0}, 1'b0};
        tbl[3] = '{4'b0010, 6,  8,  2, 3, 1, '{1, 0, 0, 0}, 1'b1};
        tbl[4] = '{4'b0100, 9, 28, -1, 0, 1, '{2, 0, 0, 0}, 1'b1};
        tbl[5] = '{4'b0101, 0,  0, -1, 0, 2, '{0, 2, 0, 0}, 1'b1};

        reset = 1'b1;
        stall = 1'b0;
        for (int b = 0; b < NB; b++) begin
            b_req[b] = 1'b0; b_len[b] = 0; b_pos[b] = 0;
            b_node[b] = '0; b_salt[b] = '0; b_rogue[b] = 1'b0;
        end
        m_last  = NB - 1;
        exp_err = 1'b0;
        n_wr    = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 3; i++) apply_row(tbl[i]);

        // Three-cycle stall once beats 0..2 have gone out.
        launch(0, 3, 6);
        run_phase(-1, 0, 0, 0, 3);
        check("stall_writes", 64'(stall_wr), 64'd0);
        check("stall_proto_err", 64'(bus.proto_err), 64'd0);

        for (int i = 3; i < 6; i++) apply_row(tbl[i]);

        // Reset in the middle of a stream with another bank pending.
        launch(0, 12, 8);
        launch(2, 13, 4);
        plan();
        got_ord.delete();
        first_gnt = -1;
        n_wr = 0;
        for (int t = 0; t < 30 && n_wr < 3; t++) begin
            cur_t = t;
            tick();
            if (t == 0) for (int b = 0; b < NB; b++) b_req[b] = 1'b0;
        end
        check("rst_pre_writes", 64'(n_wr), 64'd3);
        reset = 1'b1;
        tick();
        check_all_zero("midrst");
        reset = 1'b0;
        for (int b = 0; b < NB; b++) begin
            b_pos[b] = 0; b_len[b] = 0; b_req[b] = 1'b0;
        end
        exp_q.delete();
        m_last  = NB - 1;
        exp_err = 1'b0;
        launch(1, 14, 2);
        launch(0, 15, 2);
        run_phase(-1, 0, 0, 0, 0);
        check("rst_first_grant", 64'(got_ord.size() > 0 ? got_ord[0] : -1), 64'd0);
        check("rst_proto_err", 64'(bus.proto_err), 64'd0);

        for (int r = 0; r < 15; r++) begin
            any = 0;
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(1) == 1) begin
                    launch(b, int'($urandom_range(63)), int'($urandom_range(1, 8)));
                    any = 1;
                end
            end
            if (any == 0) launch(int'($urandom_range(NB - 1)), int'($urandom_range(63)), int'($urandom_range(1, 8)));
            run_phase(-1, 0, 25, 0, 0);
            check("rand_proto_err", 64'(bus.proto_err), 64'(exp_err));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/output_sram_collector.md
# output_sram_collector

Receive side of the bank-to-output-SRAM request/stream protocol. Latches one-cycle output requests from `NUM_BANKS` vertex accumulation banks and grants them one at a time, round-robin. It captures each granted bank's two-feature-per-beat stream (sos…eos) and writes it into the output feature SRAM, one row per beat, addressed by Node_id. It sits between the vertex accumulation banks and the output SRAM write port.

## Interface
- `NUM_BANKS`, 4: number of vertex accumulation banks.
- `FV_SIZE`, `` `FV_size ``: width of one feature value.
- `MAX_FV_NUM`, `` `MAX_FV_num ``: maximum feature values per node; must be even.
- `NODE_W`, `` $clog2(`Max_Node_id) ``: Node_id width.
- `ROWS_PER_NODE`, `MAX_FV_NUM/2`: SRAM rows reserved per node.
- `ADDR_W`, `NODE_W + $clog2(ROWS_PER_NODE)`: SRAM address width.
- Reset and clock (already decided): `reset` is synchronous and active-high; the clock is `clk`.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: synchronous active-high reset.
- `bank_pkt` input, `Bank_Req2Req_Output_SRAM [NUM_BANKS]`: per-bank packet carrying req, Grant_valid, sos, eos, data[0:1], Node_id.
- `req_grant` output, `NUM_BANKS` bits: one-hot, single-cycle grant to a bank.
- `sram_wen` output, 1 bit: SRAM row write enable.
- `sram_addr` output, `ADDR_W` bits: equals Node_id*ROWS_PER_NODE + beat index.
- `sram_wdata` output, `2*FV_SIZE` bits: {data[1], data[0]}.
- `node_done` output, 1 bit: pulses when the last row of a node is written.
- `node_done_id` output, `NODE_W` bits: Node_id of the completed node; valid while `node_done` is high.
- `busy` output, 1 bit: high when any request is pending or a transfer is in progress.
- `proto_err` output, 1 bit: sticky protocol-error flag, cleared only by reset.

## Operation
- Pending requests:
  - `pending[i]` is set when `bank_pkt[i].req` is high.
  - It is cleared in the cycle `req_grant[i]` is issued.
  - If set and clear coincide, set wins.
- State machine, states IDLE, STREAM:
  - **IDLE.** If any `pending` bit is set, the round-robin arbiter picks bank `g`. Search starts at `last_grant+1` modulo `NUM_BANKS`.
    - `req_grant[g]`=1 combinationally, this cycle only.
    - The bank answers in the same cycle with its sos beat. Capture it as beat 0 and latch `cur_bank=g` and `cur_node=Node_id`.
    - If that beat also carries eos, stay in IDLE. Otherwise go to STREAM.
    - If the granted bank drives no Grant_valid or no sos, set `proto_err`, drop the grant and stay in IDLE. The `pending` bit is not restored.
  - **STREAM.** Each cycle in which `bank_pkt[cur_bank].Grant_valid` is high is accepted as the next beat, and `beat_idx` increments.
    - A cycle without Grant_valid is a stall: no write and no error.
    - A beat with eos returns the block to IDLE.
- Every accepted beat produces one registered SRAM write.
- Beat-index overflow: a beat arriving when `beat_idx == ROWS_PER_NODE` is dropped and sets `proto_err`. The block continues to wait for eos.
- Grant_valid from any bank other than `cur_bank` (or any bank while in IDLE without a grant) is ignored and sets `proto_err`.
- `node_done` pulses with the `sram_wen` of the eos beat.
- Reset values:
  - outputs: `req_grant`=0, `sram_wen`=0, `sram_addr`=0, `sram_wdata`=0, `node_done`=0, `node_done_id`=0, `busy`=0, `proto_err`=0.
  - internal: `pending`=0, `last_grant`=NUM_BANKS-1 (so bank 0 wins first), state IDLE.
- Reset mid-transfer abandons the transfer with no further writes. The banks share the same reset.

## Timing
- Grant latency: a req pulse in cycle T gives `req_grant` at T+1 at the earliest, if IDLE and no competitor ahead in round-robin order.
- Write latency: a beat accepted in cycle T gives `sram_wen` and its addr/data at T+1 (registered).
- Back-to-back nodes: the eos beat at T returns the block to IDLE at T+1. The next grant can be issued at T+1.
- Throughput: one row per cycle while streaming. The minimum gap between node streams is 0 cycles.
- A full node of `MAX_FV_NUM` FVs is `ROWS_PER_NODE` beats. Beat 0 is sos; the last beat is eos.

## Structure
- Shared package (existing types and constants): `Bank_Req2Req_Output_SRAM` typedef, `` `FV_size ``, `` `MAX_FV_num ``, `` `Max_Node_id ``.
- Sub-module `rr_arbiter #(N)`:
  - inputs: `req[N]`, `en`.
  - outputs: one-hot `gnt[N]`.
  - internal state: the `last_grant` pointer, which advances only when `en` is high and some `gnt` bit is set.
- Top level: pending register, FSM, beat counter, address/data output registers, error logic.

## Test plan
- Single bank: bank 0 pulses req, Node_id=5, ROWS_PER_NODE=8.
  - `req_grant[0]` the next cycle.
  - 8 writes at addr 40..47 with matching data.
  - `node_done` with `node_done_id`=5 on the 8th write.
- Simultaneous req from banks 0–3: grants occur in order 0,1,2,3 with no interleaving of writes. A second round started by banks 1 and 3 grants 1 then 3.
- Stall mid-stream: Grant_valid is low for 3 cycles between beats 2 and 3. No writes during the stall, addresses stay contiguous, `proto_err`=0.
- Grant_valid from bank 2 while bank 1 is streaming: ignored, `proto_err`=1, bank 1's writes are unaffected.
- Overflow: 9 beats with no eos until the 9th. The 9th beat is dropped, `proto_err`=1, return to IDLE after eos.
- Reset asserted mid-stream after 3 writes: the next cycle all outputs are 0, `pending`=0 and `busy`=0. After reset, a new request from bank 0 is granted first.
